// File: rtl/fb_pkg.sv
// Shared framebuffer constants and the arbiter grant type.
package fb_pkg;

    localparam int unsigned FB_H_ACTIVE = 640;
    localparam int unsigned FB_V_ACTIVE = 480;
    localparam int unsigned FB_WORDS    = FB_H_ACTIVE * FB_V_ACTIVE;
    localparam int unsigned FB_ADDR_W   = 19;
    localparam int unsigned FB_DATA_W   = 12;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_DRAW = 2'd2
    } grant_t;

endpackage

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display scan reads win, bounded so renderer draws are not starved.
// FB_TEAR_GUARD_EN restricts draws to vertical blanking.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W       = FB_ADDR_W,
    parameter int unsigned DATA_W       = FB_DATA_W,
    parameter int unsigned MAX_SCAN_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vblank,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_ack,
    output logic              scan_rvalid,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned       RUN_W   = 4;
    localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(MAX_SCAN_RUN);

    logic [RUN_W-1:0]  scan_run_q,  scan_run_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]        rvalid_q,    rvalid_d;

    grant_t gnt;
    logic   draw_ok;
    logic   force_draw;

`ifdef FB_TEAR_GUARD_EN
    assign draw_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign draw_ok       = 1'b1;
`endif

    // Scan wins unless its run limit is reached while a permitted draw waits.
    always_comb begin
        gnt        = GNT_NONE;
        force_draw = draw_req && draw_ok && (scan_run_q == RUN_MAX);
        if (!reset) begin
            if (scan_req && !force_draw) begin
                gnt = GNT_SCAN;
            end else if (draw_req && draw_ok) begin
                gnt = GNT_DRAW;
            end
        end
    end

    assign scan_ack = (gnt == GNT_SCAN);
    assign draw_ack = (gnt == GNT_DRAW);

    always_comb begin
        scan_run_d  = scan_run_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rvalid_d    = {rvalid_q[0], (gnt == GNT_SCAN)};
        case (gnt)
            GNT_SCAN: begin
                if (scan_run_q != RUN_MAX) begin
                    scan_run_d = scan_run_q + 1'b1;
                end
                mem_en_d   = 1'b1;
                mem_addr_d = scan_addr;
            end
            GNT_DRAW: begin
                scan_run_d  = '0;
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = draw_addr;
                mem_wdata_d = draw_wdata;
            end
            default: begin
                if (!scan_req) begin
                    scan_run_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_run_q  <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rvalid_q    <= '0;
        end else begin
            scan_run_q  <= scan_run_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rvalid_q    <= rvalid_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign scan_rvalid = rvalid_q[1];
    // RAM output register already provides the second cycle of latency.
    assign scan_rdata  = mem_rdata;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: directed scenarios plus a randomized run against a request-level model.
`timescale 1ns/1ps
module tb_fb_arbiter;

    localparam int unsigned AW   = 19;
    localparam int unsigned DW   = 12;
    localparam int unsigned MAXR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          vblank;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic          scan_ack;
    logic          scan_rvalid;
    logic [DW-1:0] scan_rdata;
    logic          draw_req;
    logic [AW-1:0] draw_addr;
    logic [DW-1:0] draw_wdata;
    logic          draw_ack;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    int checks = 0;
    int passed = 0;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_SCAN_RUN(MAXR)) dut (
        .clk(clk), .reset(reset), .vblank(vblank),
        .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
        .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
        .draw_req(draw_req), .draw_addr(draw_addr), .draw_wdata(draw_wdata),
        .draw_ack(draw_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int a);
        return 12'(a * 5 + 32'h3A5);
    endfunction

    // Single-port RAM with one cycle of read latency; unwritten words read as init_val.
    logic [DW-1:0] ram [int];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[int'(mem_addr)] = mem_wdata;
            else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_val(int'(mem_addr));
        end
    end

`ifdef FB_TEAR_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    // Request-level model state
    int            m_run;
    logic          e_pen, e_pwe, rv0, rv1;
    logic [AW-1:0] e_paddr;
    logic [DW-1:0] e_pwdata, rd0, rd1;
    logic [DW-1:0] shadow [int];

    task automatic model_reset();
        m_run = 0; e_pen = 0; e_pwe = 0; e_paddr = '0; e_pwdata = '0;
        rv0 = 0; rv1 = 0; rd0 = '0; rd1 = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1; scan_req = 0; draw_req = 0; vblank = 0;
        scan_addr = '0; draw_addr = '0; draw_wdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1; vblank = 1; scan_req = 1; draw_req = 1;
        scan_addr = 19'h00123; draw_addr = 19'h00456; draw_wdata = 12'hABC;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (scan_ack !== 1'b0 || draw_ack !== 1'b0)
                $display("FAIL reset_acks: got scan=%b draw=%b want 0/0", scan_ack, draw_ack);
            else passed++;
            checks++;
            if (mem_en !== 0 || mem_we !== 0 || mem_addr !== '0 || mem_wdata !== '0 || scan_rvalid !== 0)
                $display("FAIL reset_outs: got en=%b we=%b addr=%h wd=%h rv=%b want all 0",
                         mem_en, mem_we, mem_addr, mem_wdata, scan_rvalid);
            else passed++;
        end
        do_reset();
    endtask

    task automatic test_scan_single();
        do_reset();
        scan_req = 1; scan_addr = 19'h00010;
        @(negedge clk);
        checks++;
        if (scan_ack !== 1 || draw_ack !== 0)
            $display("FAIL scan_single_ack: got scan=%b draw=%b want 1/0", scan_ack, draw_ack);
        else passed++;
        @(posedge clk); #1 scan_req = 0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1 || mem_we !== 0 || mem_addr !== 19'h00010 || scan_rvalid !== 0)
            $display("FAIL scan_single_mem: got en=%b we=%b addr=%h rv=%b want 1/0/00010/0",
                     mem_en, mem_we, mem_addr, scan_rvalid);
        else passed++;
        @(negedge clk);
        checks++;
        if (scan_rvalid !== 1 || scan_rdata !== init_val(16) || mem_en !== 0)
            $display("FAIL scan_single_rd: got rv=%b data=%h en=%b want 1/%h/0",
                     scan_rvalid, scan_rdata, mem_en, init_val(16));
        else passed++;
        @(negedge clk);
        checks++;
        if (scan_rvalid !== 0)
            $display("FAIL scan_single_rv_end: got %b want 0", scan_rvalid);
        else passed++;
    endtask

    task automatic test_draw_single();
        do_reset();
        vblank = 1; draw_req = 1; draw_addr = 19'h12C00; draw_wdata = 12'hF0F;
        @(negedge clk);
        checks++;
        if (draw_ack !== 1 || scan_ack !== 0)
            $display("FAIL draw_single_ack: got draw=%b scan=%b want 1/0", draw_ack, scan_ack);
        else passed++;
        @(posedge clk); #1 draw_req = 0;
        @(negedge clk);
        checks++;
        if (mem_en !== 1 || mem_we !== 1 || mem_addr !== 19'h12C00 || mem_wdata !== 12'hF0F)
            $display("FAIL draw_single_mem: got en=%b we=%b addr=%h wd=%h want 1/1/12c00/f0f",
                     mem_en, mem_we, mem_addr, mem_wdata);
        else passed++;
        @(negedge clk);
        checks++;
        if (mem_en !== 0 || mem_we !== 0 || mem_addr !== 19'h12C00 || mem_wdata !== 12'hF0F || scan_rvalid !== 0)
            $display("FAIL draw_single_hold: got en=%b we=%b addr=%h wd=%h rv=%b want 0/0/12c00/f0f/0",
                     mem_en, mem_we, mem_addr, mem_wdata, scan_rvalid);
        else passed++;
    endtask

    task automatic test_run_limit();
        do_reset();
        vblank = 1; scan_req = 1; scan_addr = 19'h00020;
        draw_req = 1; draw_addr = 19'h40000; draw_wdata = 12'h123;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (scan_ack !== ((i % 5) != 4) || draw_ack !== ((i % 5) == 4))
                $display("FAIL run_limit[%0d]: got scan=%b draw=%b want %b/%b",
                         i, scan_ack, draw_ack, (i % 5) != 4, (i % 5) == 4);
            else passed++;
            @(posedge clk); #1;
        end
        scan_req = 0; draw_req = 0;
    endtask

    task automatic test_tear_guard();
        do_reset();
        draw_req = 1; draw_addr = 19'h40010; draw_wdata = 12'h5A5; vblank = 0;
        if (GUARD) begin
            for (int i = 0; i < 100; i++) begin
                scan_req = 1'($urandom_range(0, 1)); scan_addr = 19'h00030;
                @(negedge clk);
                checks++;
                if (draw_ack !== 0 || scan_ack !== scan_req)
                    $display("FAIL guard_blocked[%0d]: got draw=%b scan=%b want 0/%b",
                             i, draw_ack, scan_ack, scan_req);
                else passed++;
                @(posedge clk); #1;
            end
            vblank = 1; scan_req = 0;
        end else begin
            scan_req = 0;
        end
        @(negedge clk);
        checks++;
        if (draw_ack !== 1 || scan_ack !== 0)
            $display("FAIL guard_release: got draw=%b scan=%b want 1/0", draw_ack, scan_ack);
        else passed++;
        @(posedge clk); #1 draw_req = 0; vblank = 0;
    endtask

    task automatic test_reset_inflight();
        do_reset();
        vblank = 1; scan_req = 1; scan_addr = 19'h00040;
        draw_req = 1; draw_addr = 19'h40020; draw_wdata = 12'h777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (scan_ack !== 1) $display("FAIL inflight_pre[%0d]: got scan_ack=%b want 1", i, scan_ack);
            else passed++;
            @(posedge clk); #1;
        end
        reset = 1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (scan_ack !== 0 || draw_ack !== 0 || scan_rvalid !== 0)
                $display("FAIL inflight_in_reset: got scan=%b draw=%b rv=%b want 0/0/0",
                         scan_ack, draw_ack, scan_rvalid);
            else passed++;
            @(posedge clk); #1;
        end
        reset = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (scan_ack !== (i != 4) || draw_ack !== (i == 4))
                $display("FAIL inflight_run[%0d]: got scan=%b draw=%b want %b/%b",
                         i, scan_ack, draw_ack, i != 4, i == 4);
            else passed++;
            checks++;
            if (scan_rvalid !== (i >= 2) || (i == 0 && mem_en !== 0))
                $display("FAIL inflight_rv[%0d]: got rv=%b en=%b want rv=%b", i, scan_rvalid, mem_en, i >= 2);
            else passed++;
            @(posedge clk); #1;
        end
        scan_req = 0; draw_req = 0;
    endtask

    task automatic test_random();
        logic ok, frc, es, ed;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (!scan_req || es) begin
                scan_req = ($urandom_range(0, 3) != 0); scan_addr = AW'($urandom_range(0, 31));
            end
            if (!draw_req || ed) begin
                draw_req = ($urandom_range(0, 2) != 0); draw_addr = AW'($urandom_range(0, 31));
                draw_wdata = DW'($urandom);
            end
            if ($urandom_range(0, 15) == 0) vblank = ~vblank;
            @(negedge clk);
            ok  = GUARD ? vblank : 1'b1;
            frc = draw_req && ok && (m_run == int'(MAXR));
            es  = scan_req && !frc;
            ed  = draw_req && ok && (!scan_req || frc);
            checks++;
            if (scan_ack !== es || draw_ack !== ed)
                $display("FAIL rand_ack[%0d]: got scan=%b draw=%b want %b/%b", c, scan_ack, draw_ack, es, ed);
            else passed++;
            checks++;
            if (mem_en !== e_pen || mem_we !== e_pwe || mem_addr !== e_paddr || (e_pwe && mem_wdata !== e_pwdata))
                $display("FAIL rand_mem[%0d]: got en=%b we=%b addr=%h wd=%h want %b/%b/%h/%h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, e_pen, e_pwe, e_paddr, e_pwdata);
            else passed++;
            checks++;
            if (scan_rvalid !== rv1 || (rv1 && scan_rdata !== rd1))
                $display("FAIL rand_rd[%0d]: got rv=%b data=%h want %b/%h", c, scan_rvalid, scan_rdata, rv1, rd1);
            else passed++;
            rv1 = rv0; rd1 = rd0; rv0 = es;
            if (es) rd0 = shadow.exists(int'(scan_addr)) ? shadow[int'(scan_addr)] : init_val(int'(scan_addr));
            if (ed) shadow[int'(draw_addr)] = draw_wdata;
            e_pen = es || ed; e_pwe = ed;
            if (es) e_paddr = scan_addr;
            if (ed) begin e_paddr = draw_addr; e_pwdata = draw_wdata; end
            m_run = es ? ((m_run < int'(MAXR)) ? m_run + 1 : int'(MAXR)) : 0;
            @(posedge clk); #1;
        end
        scan_req = 0; draw_req = 0;
    endtask

    initial begin
        test_reset();
        test_scan_single();
        test_draw_single();
        test_run_limit();
        test_tear_guard();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
